// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic parallel-camera stream source (PCLK/VSYNC/HREF/D).
// PCLK runs at clk/2. All stream outputs change only on "fall ticks" (clk edges
// where PCLK goes 1->0), so they are stable at every PCLK rising edge.
// Frame layout: VSYNC lines, back-porch lines, V_ACTIVE lines, front-porch lines.
// Each line is 2*H_ACTIVE data bytes (HREF=1) followed by H_BLANK blank cycles.
// Optional feature macro: CAM_GEN_BARS_EN selects 8 RGB565 vertical colour
// bars; without it the byte is (active line index + byte index) mod 256.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 2,
  parameter int VFP_LINES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       PCLK,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] D,
  output logic       frame_done
);

  localparam int L_LEN     = 2 * H_ACTIVE + H_BLANK;
  localparam int HREF_LEN  = 2 * H_ACTIVE;
  localparam int MAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_B     = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int COL_W     = $clog2(L_LEN);
  localparam int LINE_W    = $clog2(MAX_LINES + 1);
  localparam int BAR_W     = H_ACTIVE / 8;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(L_LEN - 1);
  localparam logic [COL_W-1:0]  HREF_END = COL_W'(HREF_LEN);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;     // PCLK cycle within the current line
  logic [LINE_W-1:0] line_q, line_d;   // line within the current phase
  logic              pclk_q, pclk_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        d_q, d_d;
  logic              frame_done_q, frame_done_d;
  logic [LINE_W-1:0] last_line_s;

  // Byte shown at a given active line / byte position while HREF is high.
  function automatic logic [7:0] pix_byte(input logic [LINE_W-1:0] line_i,
                                          input logic [COL_W-1:0]  col_i);
`ifdef CAM_GEN_BARS_EN
    logic [COL_W-1:0] x;
    logic [2:0]       bar;
    logic [15:0]      rgb;
    x   = col_i >> 1;
    bar = 3'(x / COL_W'(BAR_W));
    case (bar)
      3'd0:    rgb = 16'hFFFF;  // white
      3'd1:    rgb = 16'hFFE0;  // yellow
      3'd2:    rgb = 16'h07FF;  // cyan
      3'd3:    rgb = 16'h07E0;  // green
      3'd4:    rgb = 16'hF81F;  // magenta
      3'd5:    rgb = 16'hF800;  // red
      3'd6:    rgb = 16'h001F;  // blue
      default: rgb = 16'h0000;  // black
    endcase
    // Bars repeat on every line; the line index only matters for the counter pattern.
    pix_byte = col_i[0] ? rgb[7:0] : (rgb[15:8] | (8'(line_i) & 8'h00));
`else
    pix_byte = 8'(line_i) + 8'(col_i);
`endif
  endfunction

  // Last line index of the phase the FSM is currently in.
  always_comb begin
    last_line_s = {LINE_W{1'b0}};
    case (state_q)
      S_VSYNC:  last_line_s = LINE_W'(VSYNC_LINES - 1);
      S_VBP:    last_line_s = LINE_W'(VBP_LINES - 1);
      S_ACTIVE: last_line_s = LINE_W'(V_ACTIVE - 1);
      S_VFP:    last_line_s = LINE_W'(VFP_LINES - 1);
      default:  last_line_s = {LINE_W{1'b0}};
    endcase
  end

  // Next-state: advance the frame position on fall ticks and derive the outputs
  // for the new position so they are registered on that same tick.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    pclk_d       = ~pclk_q;
    vsync_d      = vsync_q;
    href_d       = href_q;
    d_d          = d_q;
    frame_done_d = 1'b0;
    if (pclk_q) begin
      if (state_q == S_IDLE) begin
        if (en) begin
          state_d = S_VSYNC;
          col_d   = {COL_W{1'b0}};
          line_d  = {LINE_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end else if (col_q != COL_LAST) begin
        col_d = col_q + COL_ONE;
      end else begin
        col_d = {COL_W{1'b0}};
        if (line_q != last_line_s) begin
          line_d = line_q + LINE_ONE;
        end else begin
          line_d = {LINE_W{1'b0}};
          case (state_q)
            S_VSYNC:  state_d = S_VBP;
            S_VBP:    state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFP;
            S_VFP: begin
              // Frame boundary: pulse done and either restart or park.
              frame_done_d = 1'b1;
              state_d      = en ? S_VSYNC : S_IDLE;
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
      vsync_d = (state_d == S_VSYNC);
      href_d  = (state_d == S_ACTIVE) && (col_d < HREF_END);
      d_d     = href_d ? pix_byte(line_d, col_d) : 8'h00;
    end else begin
      state_d = state_q;
    end
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= {COL_W{1'b0}};
      line_q       <= {LINE_W{1'b0}};
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      pclk_q       <= pclk_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      d_q          <= d_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign PCLK       = pclk_q;
  assign VSYNC      = vsync_q;
  assign HREF       = href_q;
  assign D          = d_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen. Two instances share one clock:
// A uses small parameters so whole frames and random en/reset traffic fit in
// a short run; B uses the default geometry for the line/VSYNC timing checks.
`timescale 1ns/1ps
module tb_cam_stream_gen;

  localparam int A_HA = 16, A_VA = 6, A_HB = 4, A_VS = 2, A_VB = 1, A_VF = 2;
  localparam int A_L     = 2 * A_HA + A_HB;                   // 36
  localparam int A_FRAME = (A_VS + A_VB + A_VA + A_VF) * A_L; // 396 PCLK
  localparam int B_HA = 160, B_VA = 120, B_HB = 16, B_VS = 3, B_VB = 2, B_VF = 2;
  localparam int B_L     = 2 * B_HA + B_HB;
  localparam int B_FRAME = (B_VS + B_VB + B_VA + B_VF) * B_L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, en_a = 1'b0, rst_b = 1'b0, en_b = 1'b0;
  logic a_pclk, a_vs, a_href, a_fd, b_pclk, b_vs, b_href, b_fd;
  logic [7:0] a_d, b_d;

  int checks = 0;
  int errors = 0;

  cam_stream_gen #(.H_ACTIVE(A_HA), .V_ACTIVE(A_VA), .H_BLANK(A_HB),
                   .VSYNC_LINES(A_VS), .VBP_LINES(A_VB), .VFP_LINES(A_VF)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .PCLK(a_pclk), .VSYNC(a_vs),
    .HREF(a_href), .D(a_d), .frame_done(a_fd));

  cam_stream_gen dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .PCLK(b_pclk), .VSYNC(b_vs),
    .HREF(b_href), .D(b_d), .frame_done(b_fd));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef CAM_GEN_BARS_EN
  logic [15:0] bar_rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  // Expected byte at active line li, byte position col.
  function automatic logic [7:0] exp_byte(input int li, input int col, input int ha);
`ifdef CAM_GEN_BARS_EN
    logic [15:0] rgb;
    rgb = bar_rgb[(col / 2) / (ha / 8)];
    return (col % 2 == 1) ? rgb[7:0] : rgb[15:8];
`else
    return 8'((li + col) % 256);
`endif
  endfunction

  // Outputs for PCLK-cycle position p within a running frame.
  function automatic void model_out(input bit run, input int p, input int ha, input int va,
                                    input int hb, input int vs, input int vb,
                                    output logic v, output logic h, output logic [7:0] d);
    int l, line, col;
    l    = 2 * ha + hb;
    line = p / l;
    col  = p % l;
    v = run && (line < vs);
    h = run && (line >= vs + vb) && (line < vs + vb + va) && (col < 2 * ha);
    d = h ? exp_byte(line - vs - vb, col, ha) : 8'h00;
  endfunction

  // Reference state: running flag plus PCLK-cycle index in the frame.
  bit ma_run = 1'b0, ma_pclk = 1'b0, ma_done = 1'b0;
  int ma_p = 0;
  bit mb_run = 1'b0, mb_pclk = 1'b0, mb_done = 1'b0;
  int mb_p = 0;

  always @(posedge clk) begin
    if (!rst_a) begin
      ma_run <= 1'b0; ma_p <= 0; ma_pclk <= 1'b0; ma_done <= 1'b0;
    end else begin
      ma_pclk <= !ma_pclk;
      ma_done <= 1'b0;
      if (ma_pclk) begin
        if (!ma_run) begin
          if (en_a) begin ma_run <= 1'b1; ma_p <= 0; end
        end else if (ma_p == A_FRAME - 1) begin
          ma_done <= 1'b1; ma_p <= 0; ma_run <= en_a;
        end else begin
          ma_p <= ma_p + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      mb_run <= 1'b0; mb_p <= 0; mb_pclk <= 1'b0; mb_done <= 1'b0;
    end else begin
      mb_pclk <= !mb_pclk;
      mb_done <= 1'b0;
      if (mb_pclk) begin
        if (!mb_run) begin
          if (en_b) begin mb_run <= 1'b1; mb_p <= 0; end
        end else if (mb_p == B_FRAME - 1) begin
          mb_done <= 1'b1; mb_p <= 0; mb_run <= en_b;
        end else begin
          mb_p <= mb_p + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    logic ev, eh;
    logic [7:0] ed;
    model_out(ma_run, ma_p, A_HA, A_VA, A_HB, A_VS, A_VB, ev, eh, ed);
    chk("A.PCLK", 32'(a_pclk), 32'(ma_pclk));
    chk("A.VSYNC", 32'(a_vs), 32'(ev));
    chk("A.HREF", 32'(a_href), 32'(eh));
    chk("A.D", 32'(a_d), 32'(ed));
    chk("A.frame_done", 32'(a_fd), 32'(ma_done));
    model_out(mb_run, mb_p, B_HA, B_VA, B_HB, B_VS, B_VB, ev, eh, ed);
    chk("B.PCLK", 32'(b_pclk), 32'(mb_pclk));
    chk("B.VSYNC", 32'(b_vs), 32'(ev));
    chk("B.HREF", 32'(b_href), 32'(eh));
    chk("B.D", 32'(b_d), 32'(ed));
    chk("B.frame_done", 32'(b_fd), 32'(mb_done));
  end

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return a_fd;
      1:       return a_href;
      2:       return a_vs;
      3:       return b_vs;
      default: return b_href;
    endcase
  endfunction

  // Wait (at negedges) until the selected output equals val, bounded.
  task automatic wait_sig(input int sel, input logic val, input int bound, input string nm);
    int n;
    n = 0;
    while (get_sig(sel) !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (get_sig(sel) !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d clks waiting for %0b", nm, bound, val);
    end
  endtask

  function automatic int clks_since(input time t);
    return int'(($time - t) / 10);
  endfunction

  logic [7:0] line0 [320];
  logic [7:0] line1 [320];

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("A.reset_outs", 32'({a_pclk, a_vs, a_href, a_fd, a_d}), 32'd0);
      chk("B.reset_outs", 32'({b_pclk, b_vs, b_href, b_fd, b_d}), 32'd0);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    fork
      begin : proc_b
        time tv, tf, tr, tl;
        int hi;
        @(negedge clk);
        chk("B.first_rise_pclk", 32'(b_pclk), 32'd1);
        chk("B.first_rise_vsync", 32'(b_vs), 32'd0);
        @(negedge clk);
        chk("B.first_fall_pclk", 32'(b_pclk), 32'd0);
        chk("B.first_fall_vsync", 32'(b_vs), 32'd1);
        tv = $time;
        wait_sig(3, 1'b0, 3000, "B.vsync_fall");
        chk("B.vsync_clks", 32'(clks_since(tv)), 32'd2016);
        tf = $time;
        wait_sig(4, 1'b1, 2000, "B.href_rise0");
        chk("B.vbp_clks", 32'(clks_since(tf)), 32'd1344);
        tr = $time;
        hi = 0;
        for (int k = 0; k < 320; k++) begin
          line0[k] = b_d;
          if (b_href) hi++;
          repeat (2) @(negedge clk);
        end
        chk("B.href_high_pclks", 32'(hi), 32'd320);
        chk("B.href_low_after", 32'(b_href), 32'd0);
        chk("B.d_blank", 32'(b_d), 32'd0);
        tl = $time;
        wait_sig(4, 1'b1, 100, "B.href_rise1");
        chk("B.hblank_clks", 32'(clks_since(tl)), 32'd32);
        chk("B.line_clks", 32'(clks_since(tr)), 32'd672);
        for (int k = 0; k < 320; k++) begin
          line1[k] = b_d;
          repeat (2) @(negedge clk);
        end
`ifdef CAM_GEN_BARS_EN
        chk("B.bar_x0_b0", 32'(line0[0]), 32'h00FF);
        chk("B.bar_x0_b1", 32'(line0[1]), 32'h00FF);
        chk("B.bar_x20_b0", 32'(line0[40]), 32'h00FF);
        chk("B.bar_x20_b1", 32'(line0[41]), 32'h00E0);
        chk("B.bar_x100_b0", 32'(line0[200]), 32'h00F8);
        chk("B.bar_x100_b1", 32'(line0[201]), 32'h0000);
        chk("B.bar_x159_b0", 32'(line0[318]), 32'h0000);
        chk("B.bar_x159_b1", 32'(line0[319]), 32'h0000);
        chk("B.bar_l1_x40", 32'(line1[80]), 32'h0007);
`else
        chk("B.l0_b0", 32'(line0[0]), 32'h0000);
        chk("B.l0_b255", 32'(line0[255]), 32'h00FF);
        chk("B.l0_b256", 32'(line0[256]), 32'h0000);
        chk("B.l1_b0", 32'(line1[0]), 32'h0001);
        chk("B.l1_b1", 32'(line1[1]), 32'h0002);
        chk("B.l1_b254", 32'(line1[254]), 32'h00FF);
        chk("B.l1_b255", 32'(line1[255]), 32'h0000);
        chk("B.l1_b319", 32'(line1[319]), 32'h0040);
`endif
      end
      begin : proc_a
        time t1;
        int hr, n, n_pulse, n_bad;
        logic prev, seen;
        wait_sig(0, 1'b1, 2000, "A.first_done");
        chk("A.vsync_with_done", 32'(a_vs), 32'd1);
        t1 = $time;
        prev = a_href;
        hr = 0;
        n = 0;
        @(negedge clk);
        while (!a_fd && n < 2000) begin
          if (a_href && !prev) hr++;
          prev = a_href;
          @(negedge clk);
          n++;
        end
        chk("A.done_seen", 32'(a_fd), 32'd1);
        chk("A.frame_clks", 32'(clks_since(t1)), 32'd792);
        chk("A.href_pulses", 32'(hr), 32'd6);
        // Drop en in the middle of the active region: frame must still finish.
        wait_sig(1, 1'b1, 2000, "A.href_mid");
        en_a = 1'b0;
        n_pulse = 0; n_bad = 0; seen = 1'b0;
        repeat (1000) begin
          @(negedge clk);
          if (a_fd) begin n_pulse++; seen = 1'b1; end
          if (seen && (a_vs || a_href)) n_bad++;
        end
        chk("A.endrop_pulses", 32'(n_pulse), 32'd1);
        chk("A.endrop_idle", 32'(n_bad), 32'd0);
        en_a = 1'b1;
        wait_sig(2, 1'b1, 10, "A.restart");
        wait_sig(1, 1'b1, 2000, "A.href_before_rst");
        rst_a = 1'b0;
        @(negedge clk);
        chk("A.midrst_outs", 32'({a_pclk, a_vs, a_href, a_fd, a_d}), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        // Random en / reset traffic checked cycle by cycle against the reference.
        for (int i = 0; i < 50; i++) begin
          en_a  = ($urandom_range(0, 3) != 0);
          rst_a = ($urandom_range(0, 9) != 0);
          repeat ($urandom_range(1, 120)) @(negedge clk);
        end
        rst_a = 1'b1;
        en_a  = 1'b1;
        repeat (900) @(negedge clk);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_gen.md
CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 Parameter H_ACTIVE, 160, active pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter V_ACTIVE, 120, active lines per frame.
REQ-003 Parameter H_BLANK, 16, PCLK cycles with HREF low at the end of each line.
REQ-004 Parameter VSYNC_LINES, 3, line periods with VSYNC high.
REQ-005 Parameter VBP_LINES, 2, blank line periods after VSYNC.
REQ-006 Parameter VFP_LINES, 2, blank line periods after the last active line.
REQ-007 clk  input  1  system clock; all logic on the rising edge.
REQ-008 rst  input  1  reset; synchronous, active-low.
REQ-009 en  input  1  frame generation enable.
REQ-010 PCLK  output  1  pixel clock, clk/2.
REQ-011 VSYNC  output  1  frame sync, active-high.
REQ-012 HREF  output  1  line-valid strobe, active-high.
REQ-013 D  output  8  pixel byte, RGB565 high byte first.
REQ-014 frame_done  output  1  one-clk pulse at end of each frame.

Function
REQ-015 PCLK SHALL toggle on every clk while rst=1; a "fall tick" is a clk edge on which PCLK goes 1->0.
REQ-016 VSYNC, HREF and D SHALL change only on fall ticks, so they are stable across every PCLK rising edge.
REQ-017 Line period L SHALL be 2*H_ACTIVE+H_BLANK PCLK cycles; the default is 336.
REQ-018 The FSM states SHALL be IDLE, VSYNC, VBP, ACTIVE, VFP; transitions occur only on fall ticks.
REQ-019 IDLE: on a fall tick with en=1, the FSM SHALL enter VSYNC and assert VSYNC on that tick; otherwise it stays in IDLE.
REQ-020 VSYNC: VSYNC=1 for VSYNC_LINES*L PCLK cycles, then the FSM enters VBP with VSYNC=0.
REQ-021 VBP: HREF=0 for VBP_LINES*L PCLK cycles, then the FSM enters ACTIVE.
REQ-022 ACTIVE: each of V_ACTIVE lines has HREF=1 for the first 2*H_ACTIVE PCLK cycles, then HREF=0 for H_BLANK cycles; the FSM then enters VFP.
REQ-023 VFP: HREF=0 for VFP_LINES*L PCLK cycles; on the final fall tick frame_done=1 for exactly one clk.
REQ-024 End of VFP: with en=1 the FSM SHALL go directly to VSYNC (back-to-back frames); with en=0 it SHALL go to IDLE.
REQ-025 Deasserting en mid-frame SHALL NOT truncate the frame; it completes through VFP.
REQ-026 While HREF=1, pixel x (0..H_ACTIVE-1) SHALL occupy two PCLK cycles: byte0 = P[15:8], then byte1 = P[7:0].
REQ-027 D SHALL be 0x00 whenever HREF=0.
REQ-028 Line and pixel counters SHALL wrap to 0 at their terminal counts; no counter may exceed its parameter range.

Reset
REQ-029 With rst=0 at a clk edge: state=IDLE, PCLK=0, VSYNC=0, HREF=0, D=0x00, frame_done=0, all counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse.
REQ-031 After release, the first fall tick SHALL occur on the second clk edge.

Configuration
REQ-032 Macro CAM_GEN_BARS_EN defined: P = 8 vertical colour bars, each H_ACTIVE/8 pixels wide, with colours in order white 0xFFFF, yellow 0xFFE0, cyan 0x07FF, green 0x07E0, magenta 0xF81F, red 0xF800, blue 0x001F, black 0x0000.
REQ-033 Macro undefined: during HREF=1, D = (line_index + byte_index_in_line) mod 256, where both indices start at 0.

Verification
REQ-034 Reset: rst=0 for 4 clks, en=1 -> PCLK, VSYNC, HREF, D and frame_done all 0 throughout reset.
REQ-035 Defaults, en=1 from reset -> VSYNC high for 1008 PCLK cycles; first HREF rises 672 PCLK cycles after VSYNC falls; each HREF pulse is 320 PCLK cycles high and 16 low; 120 pulses per frame.
REQ-036 Defaults, en=1 -> frame_done pulses every 85344 clks, and the next VSYNC rises on the same fall tick as the pulse.
REQ-037 CAM_GEN_BARS_EN, line 0 -> bytes at x=0 are 0xFF,0xFF; at x=20, 0xFF,0xE0; at x=100, 0xF8,0x00; at x=159, 0x00,0x00.
REQ-038 Without the macro, line 1 -> D values 0x01,0x02,...,0xFF,0x00,... over 320 bytes; D=0x00 during blanking.
REQ-039 en dropped mid-ACTIVE -> the frame completes, one frame_done pulse occurs, the FSM enters IDLE, and VSYNC stays 0; rst=0 mid-ACTIVE -> all outputs 0 on the next clk.
